serial_word_feeder: RTL and testbench

- Upstream stage of the bit-serial constant multipliers.
- Accepts a parallel operand word through a valid/ready handshake and emits it LSB-first, one bit per clock, on a single serial line.
- Appends GUARD extension bits so the downstream multiplier has room for product growth, then inserts GAP idle cycles so the multiplier's carry state flushes between frames.
- Frame markers (first/last) let downstream stages align words.

---
 rtl/serial_word_feeder_if.sv | 30 +++
 rtl/serial_word_feeder.sv | 145 ++++++++++++++
 tb/tb_serial_word_feeder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_feeder_if
// Description : Parallel-in handshake and serial-out frame bundle for the
//               serial word feeder. The master side supplies words and
//               consumes the serial stream. The slave side is the feeder.
// Revision    : 1.0  initial release
// ============================================================================
interface serial_word_feeder_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out;
  logic             out_valid;
  logic             out_first;
  logic             out_last;

  modport master (
    output in_data, in_valid,
    input  in_ready, out, out_valid, out_first, out_last
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out, out_valid, out_first, out_last
  );
endinterface
`default_nettype wire

// File: rtl/serial_word_feeder.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_feeder
// Description : Accepts a parallel operand word and shifts it out LSB first,
//               one bit per clock. Each frame is the word followed by GUARD
//               extension bits, and frames are separated by GAP idle cycles.
//               First and last frame markers travel with the data.
// Revision    : 1.0  initial release
// ============================================================================
module serial_word_feeder #(
  parameter int WIDTH  = 6,
  parameter int GUARD  = 3,
  parameter int GAP    = 2,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_word_feeder_if.slave  feed
);

  localparam int FRAME = WIDTH + GUARD;
  localparam int BCW   = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int GCW   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME - 1);
  localparam logic [GCW-1:0] LAST_GAP = GCW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q;
  logic [FRAME-1:0] sr_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic [GCW-1:0]   gap_cnt_q;
  logic             out_q;
  logic             out_valid_q;
  logic             out_first_q;
  logic             out_last_q;

  logic             ext_bit;
  logic [FRAME-1:0] load_word;
  logic [FRAME-1:0] sr_shift;
  logic             ready;
  logic             accept;

  // The guard bits carry either zero or the operand's sign bit.
  assign ext_bit = (SIGNED != 0) ? feed.in_data[WIDTH-1] : 1'b0;

  generate
    if (GUARD > 0) begin : g_guard
      assign load_word = {{GUARD{ext_bit}}, feed.in_data};
    end else begin : g_no_guard
      assign load_word = feed.in_data;
    end
  endgenerate

  // sr_q[0] is always the bit currently on the line, so the next bit is
  // bit 0 of the shifted register.
  assign sr_shift = sr_q >> 1;

  // Ready exactly on the cycle before a new frame may begin, and never while
  // reset is held.
  always_comb begin
    ready = 1'b0;
    if (reset) begin
      case (state_q)
        ST_IDLE:  ready = 1'b1;
        ST_GAP:   ready = (gap_cnt_q == LAST_GAP);
        ST_SHIFT: ready = (GAP == 0) && (bit_cnt_q == LAST_BIT);
        default:  ready = 1'b0;
      endcase
    end
  end

  assign accept = feed.in_valid & ready;

  // Frame sequencing FSM with registered serial outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      // An accept can only happen at a frame boundary, so it always loads.
      state_q     <= ST_SHIFT;
      sr_q        <= load_word;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      out_q       <= load_word[0];
      out_valid_q <= 1'b1;
      out_first_q <= 1'b1;
      out_last_q  <= (FRAME == 1);
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (bit_cnt_q != LAST_BIT) begin
            sr_q        <= sr_shift;
            bit_cnt_q   <= bit_cnt_q + BCW'(1);
            out_q       <= sr_shift[0];
            out_first_q <= 1'b0;
            out_last_q  <= ((bit_cnt_q + BCW'(1)) == LAST_BIT);
          end else begin
            state_q     <= (GAP > 0) ? ST_GAP : ST_IDLE;
            sr_q        <= '0;
            gap_cnt_q   <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q != LAST_GAP) begin
            gap_cnt_q <= gap_cnt_q + GCW'(1);
          end else begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
          out_first_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign feed.in_ready  = ready;
  assign feed.out       = out_q;
  assign feed.out_valid = out_valid_q;
  assign feed.out_first = out_first_q;
  assign feed.out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_feeder
// Description : Self-checking bench for serial_word_feeder. Two instances
//               share one stimulus stream: A is zero-extended with GAP=2,
//               B is sign-extended with GAP=0. A timeline reference model
//               predicts every output and ready value of both instances.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_word_feeder;

  localparam int W  = 6;
  localparam int G  = 3;
  localparam int FR = W + G;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  serial_word_feeder_if #(.WIDTH(W)) ifa ();
  serial_word_feeder_if #(.WIDTH(W)) ifb ();

  assign ifa.in_data  = in_data;
  assign ifa.in_valid = in_valid;
  assign ifb.in_data  = in_data;
  assign ifb.in_valid = in_valid;

  serial_word_feeder #(.WIDTH(W), .GUARD(G), .GAP(2), .SIGNED(0)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .feed  (ifa.slave)
  );

  serial_word_feeder #(.WIDTH(W), .GUARD(G), .GAP(0), .SIGNED(1)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .feed  (ifb.slave)
  );

  always #5 clk = ~clk;

  // Observed {in_ready, out, out_valid, out_first, out_last} per instance.
  logic [4:0] obs [2];
  assign obs[0] = {ifa.in_ready, ifa.out, ifa.out_valid, ifa.out_first, ifa.out_last};
  assign obs[1] = {ifb.in_ready, ifb.out, ifb.out_valid, ifb.out_first, ifb.out_last};

  // Reference model: the most recent accept cycle and the frame it produced.
  bit            has_acc [2];
  int            acc_cyc [2];
  logic [FR-1:0] frm     [2];
  int            cyc;

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [FR-1:0] build_frame(input logic [W-1:0] d, input int i);
    int v;
    v = (i == 1) ? int'($signed(d)) : int'(d);
    return v[FR-1:0];
  endfunction

  // Busy from accept until the last idle slot that follows the frame.
  function automatic logic exp_ready(input int i);
    if (!has_acc[i]) return 1'b1;
    return (cyc >= acc_cyc[i] + FR + gap_of(i));
  endfunction

  function automatic logic [3:0] exp_out(input int i);
    int k;
    if (has_acc[i] && cyc > acc_cyc[i] && cyc <= acc_cyc[i] + FR) begin
      k = cyc - acc_cyc[i] - 1;
      return {frm[i][k], 1'b1, (k == 0), (k == FR - 1)};
    end
    return 4'b0000;
  endfunction

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input int i, input logic [4:0] exp);
    string p;
    p = (i == 0) ? "A" : "B";
    check_bit($sformatf("%s.in_ready@%0d", p, cyc),  obs[i][4], exp[4]);
    check_bit($sformatf("%s.out@%0d", p, cyc),       obs[i][3], exp[3]);
    check_bit($sformatf("%s.out_valid@%0d", p, cyc), obs[i][2], exp[2]);
    check_bit($sformatf("%s.out_first@%0d", p, cyc), obs[i][1], exp[1]);
    check_bit($sformatf("%s.out_last@%0d", p, cyc),  obs[i][0], exp[0]);
  endtask

  // One clock: check at the falling edge, update the model at the rising edge.
  task automatic step();
    logic acc [2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_all(i, {exp_ready(i), exp_out(i)});
      acc[i] = in_valid && exp_ready(i);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        has_acc[i] = 1'b1;
        acc_cyc[i] = cyc;
        frm[i]     = build_frame(in_data, i);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic send_one(input logic [W-1:0] d, input int drain);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    repeat (drain) step();
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      has_acc[i] = 1'b0;
      acc_cyc[i] = 0;
      frm[i]     = '0;
    end

    // Reset state, including in_ready held low during reset.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) check_all(i, 5'b00000);
    @(posedge clk);
    #1 reset = 1'b1;

    // Idle with in_data toggling: nothing leaves the block.
    repeat (4) begin
      in_data = W'($urandom);
      step();
    end

    // Zero-extended 49, sign-extended 43, then 5.
    send_one(6'd49, 14);
    send_one(6'b101011, 14);
    send_one(6'd5, 14);

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    in_data  = 6'd49;
    repeat (12) step();
    in_data  = 6'd5;
    repeat (24) step();
    in_valid = 1'b0;
    repeat (14) step();

    // Asynchronous reset while bit 4 is on the line.
    in_valid = 1'b1;
    in_data  = W'($urandom);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check_bit("A.out_valid_bit4", obs[0][2], 1'b1);
    check_bit("B.out_valid_bit4", obs[1][2], 1'b1);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) check_all(i, 5'b00000);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_all(i, 5'b00000);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc = cyc + 2;
    for (int i = 0; i < 2; i++) has_acc[i] = 1'b0;
    repeat (3) step();
    send_one(W'($urandom), 14);

    // Randomized traffic.
    repeat (3000) begin
      in_valid = ($urandom_range(0, 9) < 6);
      in_data  = W'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (14) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
